note_highway_ctrl: RTL
======================

NOTE_HIGHWAY_CTRL -- requirements
Module: note_highway_ctrl

Interface
REQ-001 Parameter LANES, default 4, number of note lanes (columns) drawn per frame.
REQ-002 Parameter ROWS, default 8, number of visible note boxes per lane.
REQ-003 Parameter BOX_W, default 8, box width in pixels.
REQ-004 Parameter BOX_H, default 8, box height in pixels.
REQ-005 Parameter SCREEN_PIXELS, default 19200, pixel count of the full-screen background clear.
REQ-006 Parameter BEAT_CYCLES, default 12500000, clock cycles per song beat.
REQ-007 Parameter SONG_LEN, default 256, number of beats in the song.
REQ-008 clock  in  1  system clock; all state changes on its rising edge.
REQ-009 reset  in  1  asynchronous, active-low reset.
REQ-010 start  in  1  level; sampled only in IDLE and DONE.
REQ-011 loadDefault  out  1  one-cycle pulse that loads the background colour/address.
REQ-012 writeDefault  out  1  high while clearing the screen.
REQ-013 gridCounter  out  clog2(SCREEN_PIXELS)  background pixel index.
REQ-014 shiftSong  out  1  one-cycle pulse that advances the song shift register.
REQ-015 songCounter  out  clog2(SONG_LEN)  current beat index.
REQ-016 loadStartAddress, loadX, loadY  out  1 each  one-cycle pulses that latch the box origin.
REQ-017 laneIdx  out  clog2(LANES)  and  rowIdx  out  clog2(ROWS)  box being drawn.
REQ-018 writeToScreen  out  1  high while drawing box pixels.
REQ-019 pixelCount  out  clog2(BOX_W*BOX_H)  pixel index inside the box, row-major.
REQ-020 songDone  out  1  song-complete flag.
REQ-021 busy  out  1  high in every state except IDLE and DONE.

Function
REQ-022 States: IDLE, CLR_LOAD, CLR_WRITE, WAIT_BEAT, SHIFT, BOX_LOAD, BOX_DRAW, DONE.
REQ-023 IDLE: start=1 -> CLR_LOAD; CLR_LOAD lasts 1 cycle with loadDefault=1 -> CLR_WRITE.
REQ-024 CLR_WRITE: writeDefault=1 for exactly SCREEN_PIXELS cycles, gridCounter 0..SCREEN_PIXELS-1, then -> WAIT_BEAT with songCounter=0.
REQ-025 WAIT_BEAT: beat counter runs only in this state; after BEAT_CYCLES cycles -> SHIFT.
REQ-026 SHIFT: 1 cycle, shiftSong=1; laneIdx=rowIdx=0 -> BOX_LOAD.
REQ-027 BOX_LOAD: 1 cycle, loadStartAddress=loadX=loadY=1 -> BOX_DRAW.
REQ-028 BOX_DRAW: writeToScreen=1 for BOX_W*BOX_H cycles, pixelCount 0..BOX_W*BOX_H-1.
REQ-029 After the last pixel: rowIdx increments; at ROWS-1 it wraps to 0 and laneIdx increments; the next state is BOX_LOAD unless laneIdx=LANES-1 and rowIdx=ROWS-1.
REQ-030 Frame end, songCounter<SONG_LEN-1: songCounter+1 -> WAIT_BEAT.
REQ-031 Frame end, songCounter=SONG_LEN-1: behaviour set by REQ-038/039.
REQ-032 DONE: songDone=1, busy=0; start=1 -> CLR_LOAD, clears songDone, restarts at beat 0.
REQ-033 start is ignored while busy=1.
REQ-034 All pulse outputs are 0 outside their stated state; counters hold their value outside their state.
REQ-035 Per-beat cycle count = BEAT_CYCLES + 1 + LANES*ROWS*(1+BOX_W*BOX_H).

Reset
REQ-036 reset=0 at any time, mid-frame included, forces IDLE immediately and zeros every counter and output; busy=0 and songDone=0.
REQ-037 First state change after reset release occurs on the first rising edge with reset=1.

Configuration
REQ-038 With NOTE_HIGHWAY_LOOP_EN defined, the last frame end wraps songCounter to 0, pulses songDone for one cycle, and goes -> WAIT_BEAT; DONE is unreachable.
REQ-039 Without NOTE_HIGHWAY_LOOP_EN, the last frame end goes -> DONE with songCounter held at SONG_LEN-1.

Verification
Bench parameters: LANES=2, ROWS=2, BOX_W=2, BOX_H=2, SCREEN_PIXELS=16, BEAT_CYCLES=4, SONG_LEN=3.
REQ-040 Pulse start in IDLE -> loadDefault for 1 cycle, then writeDefault for 16 cycles with gridCounter 0..15, then busy=1 in WAIT_BEAT.
REQ-041 One beat -> 4 wait cycles, shiftSong pulse, 4 boxes (lane,row) = (0,0),(0,1),(1,0),(1,1), each with 1 load cycle + 4 write cycles; 25 cycles per beat.
REQ-042 Loop macro off -> songCounter goes 0,1,2; after the third frame, DONE with songDone=1 and busy=0; start restarts at beat 0.
REQ-043 Loop macro on -> after beat 2, songDone high for exactly 1 cycle, songCounter=0, shifting continues.
REQ-044 reset=0 during BOX_DRAW at pixelCount=2 -> all outputs 0 in the same cycle; after release, start is needed again.
REQ-045 start held high throughout a frame -> no restart and no change in the cycle counts above.

Source files
------------

// File: rtl/note_highway_ctrl.sv
// Sequencer for a falling-note display: clears the screen, then each beat shifts the
// song and redraws a LANES x ROWS grid of boxes. Define NOTE_HIGHWAY_LOOP_EN to loop the song.
module note_highway_ctrl #(
  parameter int LANES         = 4,
  parameter int ROWS          = 8,
  parameter int BOX_W         = 8,
  parameter int BOX_H         = 8,
  parameter int SCREEN_PIXELS = 19200,
  parameter int BEAT_CYCLES   = 12500000,
  parameter int SONG_LEN      = 256
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  output logic                               loadDefault,
  output logic                               writeDefault,
  output logic [$clog2(SCREEN_PIXELS)-1:0]   gridCounter,
  output logic                               shiftSong,
  output logic [$clog2(SONG_LEN)-1:0]        songCounter,
  output logic                               loadStartAddress,
  output logic                               loadX,
  output logic                               loadY,
  output logic [$clog2(LANES)-1:0]           laneIdx,
  output logic [$clog2(ROWS)-1:0]            rowIdx,
  output logic                               writeToScreen,
  output logic [$clog2(BOX_W*BOX_H)-1:0]     pixelCount,
  output logic                               songDone,
  output logic                               busy
);

  localparam int GW = $clog2(SCREEN_PIXELS);
  localparam int SW = $clog2(SONG_LEN);
  localparam int LW = $clog2(LANES);
  localparam int RW = $clog2(ROWS);
  localparam int PW = $clog2(BOX_W*BOX_H);
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;

  localparam logic [GW-1:0] GRID_LAST = GW'(SCREEN_PIXELS - 1);
  localparam logic [SW-1:0] SONG_LAST = SW'(SONG_LEN - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [PW-1:0] PIX_LAST  = PW'(BOX_W*BOX_H - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CLR_LOAD, CLR_WRITE, WAIT_BEAT, SHIFT, BOX_LOAD, BOX_DRAW, DONE
  } stateT;

  stateT         stateReg, stateNext;
  logic [GW-1:0] gridReg, gridNext;
  logic [SW-1:0] songReg, songNext;
  logic [LW-1:0] laneReg, laneNext;
  logic [RW-1:0] rowReg, rowNext;
  logic [PW-1:0] pixReg, pixNext;
  logic [BW-1:0] beatReg, beatNext;
`ifdef NOTE_HIGHWAY_LOOP_EN
  logic          doneReg, doneNext;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      gridReg  <= '0;
      songReg  <= '0;
      laneReg  <= '0;
      rowReg   <= '0;
      pixReg   <= '0;
      beatReg  <= '0;
`ifdef NOTE_HIGHWAY_LOOP_EN
      doneReg  <= 1'b0;
`endif
    end else begin
      stateReg <= stateNext;
      gridReg  <= gridNext;
      songReg  <= songNext;
      laneReg  <= laneNext;
      rowReg   <= rowNext;
      pixReg   <= pixNext;
      beatReg  <= beatNext;
`ifdef NOTE_HIGHWAY_LOOP_EN
      doneReg  <= doneNext;
`endif
    end
  end

  always_comb begin
    stateNext        = stateReg;
    gridNext         = gridReg;
    songNext         = songReg;
    laneNext         = laneReg;
    rowNext          = rowReg;
    pixNext          = pixReg;
    beatNext         = beatReg;
`ifdef NOTE_HIGHWAY_LOOP_EN
    doneNext         = 1'b0;
`endif
    loadDefault      = 1'b0;
    writeDefault     = 1'b0;
    shiftSong        = 1'b0;
    loadStartAddress = 1'b0;
    loadX            = 1'b0;
    loadY            = 1'b0;
    writeToScreen    = 1'b0;

    case (stateReg)
      IDLE: if (start) stateNext = CLR_LOAD;
      CLR_LOAD: begin
        loadDefault = 1'b1;
        gridNext    = '0;
        stateNext   = CLR_WRITE;
      end
      CLR_WRITE: begin
        writeDefault = 1'b1;
        if (gridReg == GRID_LAST) begin
          songNext  = '0;
          beatNext  = '0;
          stateNext = WAIT_BEAT;
        end else begin
          gridNext = gridReg + GW'(1);
        end
      end
      WAIT_BEAT: begin
        if (beatReg == BEAT_LAST) begin
          beatNext  = '0;
          stateNext = SHIFT;
        end else begin
          beatNext = beatReg + BW'(1);
        end
      end
      SHIFT: begin
        shiftSong = 1'b1;
        laneNext  = '0;
        rowNext   = '0;
        stateNext = BOX_LOAD;
      end
      BOX_LOAD: begin
        loadStartAddress = 1'b1;
        loadX            = 1'b1;
        loadY            = 1'b1;
        pixNext          = '0;
        stateNext        = BOX_DRAW;
      end
      BOX_DRAW: begin
        writeToScreen = 1'b1;
        if (pixReg != PIX_LAST) begin
          pixNext = pixReg + PW'(1);
        end else if (laneReg == LANE_LAST && rowReg == ROW_LAST) begin
          // Frame complete: either advance to the next beat or finish the song.
          if (songReg != SONG_LAST) begin
            songNext  = songReg + SW'(1);
            stateNext = WAIT_BEAT;
          end else begin
`ifdef NOTE_HIGHWAY_LOOP_EN
            songNext  = '0;
            doneNext  = 1'b1;
            stateNext = WAIT_BEAT;
`else
            stateNext = DONE;
`endif
          end
        end else begin
          stateNext = BOX_LOAD;
          if (rowReg == ROW_LAST) begin
            rowNext  = '0;
            laneNext = laneReg + LW'(1);
          end else begin
            rowNext = rowReg + RW'(1);
          end
        end
      end
      DONE: if (start) stateNext = CLR_LOAD;
      default: stateNext = IDLE;
    endcase
  end

  assign gridCounter = gridReg;
  assign songCounter = songReg;
  assign laneIdx     = laneReg;
  assign rowIdx      = rowReg;
  assign pixelCount  = pixReg;
  assign busy        = (stateReg != IDLE) && (stateReg != DONE);
`ifdef NOTE_HIGHWAY_LOOP_EN
  assign songDone    = doneReg;
`else
  assign songDone    = (stateReg == DONE);
`endif

endmodule
